rf_sequencer: RTL and testbench

- Control sequencer for the 4-entry register file datapath.
- Accepts encoded micro-instructions over a valid/ready handshake, decodes them and drives every RF control input: source select, write address/enable, read addresses, destination selects.
- Sequences multi-cycle EXEC operations: read operands, start the external execute unit, wait for its done, write result C back. Includes a timeout guard.
- Sits between the instruction source and the RF/execute unit.

---
 rtl/rf_sequencer_if.sv | 23 ++
 rtl/rf_sequencer.sv | 155 +++++++++++++++
 tb/tb_rf_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_sequencer_if.sv
// Instruction handshake between an instruction source and rf_sequencer.
// Width follows the RF address width.
interface rf_sequencer_if #(
  parameter int ADDR_BITS = 2
);
  localparam int INSTR_W = 2 + 3 * ADDR_BITS + 4;

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;

  modport master (
    output instr,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/rf_sequencer.sv
// Control sequencer for the register file datapath: decodes micro-instructions
// and drives RF controls, sequencing multi-cycle EXEC operations with a timeout.
module rf_sequencer #(
  parameter int ADDR_BITS = 2,
  parameter int INSTR_W   = 2 + 3 * ADDR_BITS + 4,
  parameter int TIMEOUT   = 15,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_sequencer_if.slave        cmd,
  input  logic                 exec_done,
  output logic [1:0]           rf_select_source,
  output logic [ADDR_BITS-1:0] rf_write_address,
  output logic                 rf_write_en,
  output logic [ADDR_BITS-1:0] rf_read_address_a,
  output logic [ADDR_BITS-1:0] rf_read_address_b,
  output logic                 rf_select_dest_a,
  output logic                 rf_select_dest_b,
  output logic                 rd_strobe,
  output logic                 exec_start,
  output logic                 busy,
  output logic                 err,
  output logic [CNT_W-1:0]     retired
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_EXEC = 2'b11;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]           state;
  logic [INSTR_W-1:0]   ir;
  logic [TW-1:0]        tcnt;
  logic [INSTR_W-1:0]   instr_in;
  logic [1:0]           op_in;

  logic [1:0]           op;
  logic [ADDR_BITS-1:0] wa;
  logic [ADDR_BITS-1:0] ra;
  logic [ADDR_BITS-1:0] rb;
  logic                 dsel_a;
  logic                 dsel_b;
  logic [1:0]           src;

  assign instr_in = cmd.instr;
  assign op_in    = instr_in[INSTR_W-1 -: 2];

  assign op     = ir[INSTR_W-1 -: 2];
  assign wa     = ir[INSTR_W-3 -: ADDR_BITS];
  assign ra     = ir[INSTR_W-3-ADDR_BITS -: ADDR_BITS];
  assign rb     = ir[ADDR_BITS+3 -: ADDR_BITS];
  assign dsel_a = ir[3];
  assign dsel_b = ir[2];
  assign src    = ir[1:0];

  assign cmd.instr_ready = (state == S_IDLE);
  assign busy            = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ir      <= '0;
      tcnt    <= '0;
      err     <= 1'b0;
      retired <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd.instr_valid) begin
            if (op_in == OP_NOP) begin
              retired <= retired + CNT_W'(1);
            end else begin
              ir    <= instr_in;
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          tcnt <= '0;
          if (op == OP_EXEC) begin
            state <= S_WAIT;
          end else begin
            retired <= retired + CNT_W'(1);
            state   <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (exec_done) begin
            state <= S_WB;
          end else if (tcnt == TO_LAST) begin
            // abort without write-back; the instruction does not retire
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_WB: begin
          retired <= retired + CNT_W'(1);
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rf_select_source  = 2'b00;
    rf_write_address  = '0;
    rf_write_en       = 1'b0;
    rf_read_address_a = '0;
    rf_read_address_b = '0;
    rf_select_dest_a  = 1'b0;
    rf_select_dest_b  = 1'b0;
    rd_strobe         = 1'b0;
    exec_start        = 1'b0;
    unique case (1'b1)
      (state == S_ISSUE): begin
        rf_read_address_a = ra;
        rf_read_address_b = rb;
        rf_select_dest_a  = dsel_a;
        rf_select_dest_b  = dsel_b;
        if (op == OP_LOAD) begin
          rf_write_en      = 1'b1;
          rf_select_source = src;
          rf_write_address = wa;
        end
        rd_strobe  = (op == OP_READ);
        exec_start = (op == OP_EXEC);
      end
      (state == S_WAIT): begin
        rf_read_address_a = ra;
        rf_read_address_b = rb;
        rf_select_dest_a  = dsel_a;
        rf_select_dest_b  = dsel_b;
      end
      (state == S_WB): begin
        rf_write_en      = 1'b1;
        rf_select_source = 2'b10;
        rf_write_address = wa;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rf_sequencer.sv
// Directed bench for rf_sequencer with a small RF write model and a
// narrow-counter instance for wrap checking.
module tb_rf_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic exec_done;

  always #5 clk = ~clk;

  rf_sequencer_if #(.ADDR_BITS(2)) bus ();
  rf_sequencer_if #(.ADDR_BITS(2)) bus_w ();

  assign bus_w.instr       = bus.instr;
  assign bus_w.instr_valid = bus.instr_valid;

  logic [1:0]  sel_src;
  logic [1:0]  wr_addr;
  logic        wr_en;
  logic [1:0]  rd_a;
  logic [1:0]  rd_b;
  logic        dsel_a;
  logic        dsel_b;
  logic        rd_strobe;
  logic        exec_start;
  logic        busy;
  logic        err;
  logic [15:0] retired;

  logic [1:0]  w_src;
  logic [1:0]  w_wa;
  logic        w_we;
  logic [1:0]  w_ra;
  logic [1:0]  w_rb;
  logic        w_da;
  logic        w_db;
  logic        w_rd;
  logic        w_st;
  logic        w_busy;
  logic        w_err;
  logic [1:0]  w_retired;

  rf_sequencer #(.ADDR_BITS(2), .TIMEOUT(15), .CNT_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .cmd               (bus),
    .exec_done         (exec_done),
    .rf_select_source  (sel_src),
    .rf_write_address  (wr_addr),
    .rf_write_en       (wr_en),
    .rf_read_address_a (rd_a),
    .rf_read_address_b (rd_b),
    .rf_select_dest_a  (dsel_a),
    .rf_select_dest_b  (dsel_b),
    .rd_strobe         (rd_strobe),
    .exec_start        (exec_start),
    .busy              (busy),
    .err               (err),
    .retired           (retired)
  );

  rf_sequencer #(.ADDR_BITS(2), .TIMEOUT(15), .CNT_W(2)) dut_w (
    .clk               (clk),
    .rst               (rst),
    .cmd               (bus_w),
    .exec_done         (exec_done),
    .rf_select_source  (w_src),
    .rf_write_address  (w_wa),
    .rf_write_en       (w_we),
    .rf_read_address_a (w_ra),
    .rf_read_address_b (w_rb),
    .rf_select_dest_a  (w_da),
    .rf_select_dest_b  (w_db),
    .rd_strobe         (w_rd),
    .exec_start        (w_st),
    .busy              (w_busy),
    .err               (w_err),
    .retired           (w_retired)
  );

  // RF write port model: A/B/C inputs, source 11 writes zero
  logic [7:0] rf [4];
  logic [7:0] rf_a;
  logic [7:0] rf_b;
  logic [7:0] rf_c;

  always @(posedge clk) begin
    if (wr_en) begin
      case (sel_src)
        2'b00:   rf[wr_addr] <= rf_a;
        2'b01:   rf[wr_addr] <= rf_b;
        2'b10:   rf[wr_addr] <= rf_c;
        default: rf[wr_addr] <= 8'h00;
      endcase
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [11:0] i);
    bus.instr       = i;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
  endtask

  int nbusy;
  int nwe;

  initial begin
    for (int k = 0; k < 4; k++) rf[k] = 8'h00;
    rf_a = 8'hA1;
    rf_b = 8'h5A;
    rf_c = 8'h33;
    rst = 1'b1;
    exec_done = 1'b0;
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.instr_ready), 32'd1);

    // LOAD wa=3 src=B
    send({2'b01, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 2'b01});
    chk("load_we", 32'(wr_en), 32'd1);
    chk("load_wa", 32'(wr_addr), 32'd3);
    chk("load_src", 32'(sel_src), 32'd1);
    chk("load_ready", 32'(bus.instr_ready), 32'd0);
    @(negedge clk);
    chk("load_we_off", 32'(wr_en), 32'd0);
    chk("load_ready_back", 32'(bus.instr_ready), 32'd1);
    chk("load_rf3", 32'(rf[3]), 32'h5A);
    chk("load_retired", 32'(retired), 32'd1);

    // READ ra=1 rb=2 dselA=1 dselB=0
    send({2'b10, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 2'b00});
    chk("read_strobe", 32'(rd_strobe), 32'd1);
    chk("read_ra", 32'(rd_a), 32'd1);
    chk("read_rb", 32'(rd_b), 32'd2);
    chk("read_dsel", {30'd0, dsel_a, dsel_b}, 32'd2);
    chk("read_we", 32'(wr_en), 32'd0);
    @(negedge clk);
    chk("read_strobe_off", 32'(rd_strobe), 32'd0);
    chk("read_ra_off", 32'(rd_a), 32'd0);
    chk("read_retired", 32'(retired), 32'd2);

    // EXEC wa=2 ra=0 rb=3, done in 4th cycle after start
    nbusy = 0;
    send({2'b11, 2'd2, 2'd0, 2'd3, 1'b0, 1'b0, 2'b00});
    chk("exec_start", 32'(exec_start), 32'd1);
    nbusy += int'(busy);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      nbusy += int'(busy);
      chk($sformatf("exec_wait_rb_%0d", c), 32'(rd_b), 32'd3);
      chk($sformatf("exec_wait_st_%0d", c), 32'(exec_start), 32'd0);
      if (c == 5) exec_done = 1'b1;
    end
    @(negedge clk);
    exec_done = 1'b0;
    nbusy += int'(busy);
    chk("wb_we", 32'(wr_en), 32'd1);
    chk("wb_src", 32'(sel_src), 32'd2);
    chk("wb_wa", 32'(wr_addr), 32'd2);
    @(negedge clk);
    nbusy += int'(busy);
    chk("exec_busy_cycles", 32'(nbusy), 32'd6);
    chk("exec_rf2", 32'(rf[2]), 32'h33);
    chk("exec_retired", 32'(retired), 32'd3);

    // EXEC timeout; done during ISSUE must be ignored
    nwe = 0;
    send({2'b11, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 2'b00});
    exec_done = 1'b1;
    nwe += int'(wr_en);
    @(negedge clk);
    exec_done = 1'b0;
    chk("issue_done_ignored", 32'(busy), 32'd1);
    for (int c = 1; c < 15; c++) begin
      nwe += int'(wr_en);
      @(negedge clk);
    end
    chk("to_err_before", 32'(err), 32'd0);
    chk("to_busy_before", 32'(busy), 32'd1);
    nwe += int'(wr_en);
    @(negedge clk);
    chk("to_err", 32'(err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_no_write", 32'(nwe), 32'd0);
    chk("to_retired", 32'(retired), 32'd3);

    send({2'b01, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 2'b00});
    @(negedge clk);
    chk("post_to_rf1", 32'(rf[1]), 32'hA1);
    chk("post_to_retired", 32'(retired), 32'd4);
    chk("err_sticky", 32'(err), 32'd1);

    // reset mid-WAIT
    send({2'b11, 2'd0, 2'd2, 2'd1, 1'b1, 1'b1, 2'b00});
    repeat (2) @(negedge clk);
    chk("midwait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_outs", {22'd0, sel_src, wr_addr, wr_en, rd_a, rd_b, dsel_a,
                     dsel_b, rd_strobe, exec_start}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst2_err", 32'(err), 32'd0);
    chk("rst2_retired", 32'(retired), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);

    // back-to-back NOPs
    nbusy = 0;
    bus.instr = '0;
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nbusy += int'(busy);
    end
    bus.instr_valid = 1'b0;
    chk("nop_busy", 32'(nbusy), 32'd0);
    chk("nop_retired", 32'(retired), 32'd5);
    chk("nop_wrap", 32'(w_retired), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
